// File: rtl/vote_collector.sv
// vote_collector: front-end for the 4-voter majority/tie circuit.
// Synchronises and debounces a YES and a NO button per voter, locks each
// voter's first valid press during an OPEN session, then holds the YES
// vector stable (votes_valid) until cleared.
// Optional feature macro: VOTE_TIMEOUT_EN (session closes after
// TIMEOUT_CYCLES cycles in OPEN; otherwise only when all four have voted).
module vote_collector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       clear,
    input  logic [3:0] yes_btn,
    input  logic [3:0] no_btn,
    output logic [3:0] votes,
    output logic [3:0] voted,
    output logic       votes_valid,
    output logic       busy,
    output logic       timed_out
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Bits [3:0] are the YES buttons, bits [7:4] the NO buttons.
    logic [7:0]       sync1_q, sync2_q;
    logic [7:0]       db_q, db_prev_q;
    logic [CNT_W-1:0] cnt_q [8];

    logic [3:0] votes_q, votes_d;
    logic [3:0] voted_q, voted_d;
    logic [7:0] rise;
    logic [3:0] yes_ok, no_ok;

`ifdef VOTE_TIMEOUT_EN
    logic [15:0] timer_q, timer_d;
    logic        timed_out_q, timed_out_d;
`else
    logic unused_timeout_param;
    assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

    // Two-flop synchronisers and consecutive-sample debouncers for all eight buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= {no_btn, yes_btn};
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            for (int i = 0; i < 8; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_q[i] <= '0;
                    db_q[i]  <= ~db_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // A vote needs a clean rising edge on one button while the other is low;
    // a button held across session open never produces a rise.
    always_comb begin
        rise   = db_q & ~db_prev_q;
        yes_ok = rise[3:0] & ~db_q[7:4] & ~voted_q;
        no_ok  = rise[7:4] & ~db_q[3:0] & ~voted_q;
    end

    // Session state, vote latches and (optionally) the timeout timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            votes_q     <= '0;
            voted_q     <= '0;
`ifdef VOTE_TIMEOUT_EN
            timer_q     <= '0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            votes_q     <= votes_d;
            voted_q     <= voted_d;
`ifdef VOTE_TIMEOUT_EN
            timer_q     <= timer_d;
            timed_out_q <= timed_out_d;
`endif
        end
    end

    // Next-state logic: open on start, close on full vote or timeout, release on clear.
    always_comb begin
        state_d     = state_q;
        votes_d     = votes_q;
        voted_d     = voted_q;
`ifdef VOTE_TIMEOUT_EN
        timer_d     = timer_q;
        timed_out_d = timed_out_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_OPEN;
                    votes_d     = '0;
                    voted_d     = '0;
`ifdef VOTE_TIMEOUT_EN
                    timer_d     = '0;
                    timed_out_d = 1'b0;
`endif
                end
            end
            S_OPEN: begin
                voted_d = voted_q | yes_ok | no_ok;
                votes_d = votes_q | yes_ok;
`ifdef VOTE_TIMEOUT_EN
                timer_d = timer_q + 16'd1;
`endif
                if (voted_d == 4'b1111) begin
                    state_d = S_DONE;
`ifdef VOTE_TIMEOUT_EN
                end else if (timer_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = S_DONE;
                    timed_out_d = 1'b1;
`endif
                end
            end
            S_DONE: begin
                if (clear) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign votes       = votes_q;
    assign voted       = voted_q;
    assign busy        = (state_q == S_OPEN);
    assign votes_valid = (state_q == S_DONE);
`ifdef VOTE_TIMEOUT_EN
    assign timed_out   = timed_out_q;
`else
    assign timed_out   = 1'b0;
`endif

endmodule

// File: tb/tb_vote_collector.sv
// Directed testbench for vote_collector (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64).
module tb_vote_collector;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       clear;
    logic [3:0] yes_btn;
    logic [3:0] no_btn;
    logic [3:0] votes;
    logic [3:0] voted;
    logic       votes_valid;
    logic       busy;
    logic       timed_out;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    vote_collector #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .clear      (clear),
        .yes_btn    (yes_btn),
        .no_btn     (no_btn),
        .votes      (votes),
        .voted      (voted),
        .votes_valid(votes_valid),
        .busy       (busy),
        .timed_out  (timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic open_session();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic close_session();
        yes_btn = 4'b0000;
        no_btn  = 4'b0000;
        clear   = 1'b1;
        tick(1);
        clear   = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; clear = 1'b0; yes_btn = '0; no_btn = '0;
        #1 rst_n = 1'b0;
        tick(2);
        tot_cnt++;
        if ({votes, voted, votes_valid, busy, timed_out} !== 11'b0)
            $display("FAIL reset_outputs got=%b exp=%b", {votes, voted, votes_valid, busy, timed_out}, 11'b0);
        else pass_cnt++;
        rst_n = 1'b1;
        tick(2);
        tot_cnt++;
        if (busy !== 1'b0 || votes_valid !== 1'b0)
            $display("FAIL reset_idle got busy=%b valid=%b exp=0 0", busy, votes_valid);
        else pass_cnt++;
    endtask

    task automatic test_basic_vote();
        open_session();
        tot_cnt++;
        if (busy !== 1'b1) $display("FAIL t1_busy got=%b exp=1", busy);
        else pass_cnt++;
        yes_btn = 4'b0111;
        no_btn  = 4'b1000;
        tick(6);
        tot_cnt++;
        if (voted !== 4'b0000) $display("FAIL t1_voted_edge6 got=%b exp=0000", voted);
        else pass_cnt++;
        tick(1);
        tot_cnt++;
        if (voted !== 4'b1111 || votes !== 4'b0111)
            $display("FAIL t1_edge7 got voted=%b votes=%b exp 1111 0111", voted, votes);
        else pass_cnt++;
        tot_cnt++;
        if (votes_valid !== 1'b1 || busy !== 1'b0 || timed_out !== 1'b0)
            $display("FAIL t1_done got valid=%b busy=%b to=%b exp 1 0 0", votes_valid, busy, timed_out);
        else pass_cnt++;
        tick(1);
        close_session();
        tot_cnt++;
        if (votes_valid !== 1'b0 || votes !== 4'b0111)
            $display("FAIL t1_after_clear got valid=%b votes=%b exp 0 0111", votes_valid, votes);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        open_session();
        yes_btn = 4'b0010;
        tick(3);
        yes_btn = 4'b0000;
        clear   = 1'b1;
        tick(1);
        clear   = 1'b0;
        tot_cnt++;
        if (busy !== 1'b1) $display("FAIL t2_clear_in_open got busy=%b exp=1", busy);
        else pass_cnt++;
        tick(9);
        tot_cnt++;
        if (voted !== 4'b0000) $display("FAIL t2_glitch got voted=%b exp=0000", voted);
        else pass_cnt++;
        yes_btn = 4'b0010;
        tick(7);
        tot_cnt++;
        if (voted !== 4'b0010 || votes !== 4'b0010)
            $display("FAIL t2_press got voted=%b votes=%b exp 0010 0010", voted, votes);
        else pass_cnt++;
        tick(3);
        yes_btn = 4'b0001;
        no_btn  = 4'b1100;
        tick(7);
        tot_cnt++;
        if (votes_valid !== 1'b1 || votes !== 4'b0011 || voted !== 4'b1111)
            $display("FAIL t2_done got valid=%b votes=%b voted=%b exp 1 0011 1111", votes_valid, votes, voted);
        else pass_cnt++;
        close_session();
    endtask

    task automatic test_timeout();
        open_session();
        yes_btn = 4'b1001;
        tick(63);
        tot_cnt++;
        if (busy !== 1'b1 || voted !== 4'b1001)
            $display("FAIL t3_before got busy=%b voted=%b exp 1 1001", busy, voted);
        else pass_cnt++;
        tick(1);
`ifdef VOTE_TIMEOUT_EN
        tot_cnt++;
        if (votes_valid !== 1'b1 || busy !== 1'b0)
            $display("FAIL t3_done got valid=%b busy=%b exp 1 0", votes_valid, busy);
        else pass_cnt++;
        tot_cnt++;
        if (votes !== 4'b1001 || voted !== 4'b1001 || timed_out !== 1'b1)
            $display("FAIL t3_result got votes=%b voted=%b to=%b exp 1001 1001 1", votes, voted, timed_out);
        else pass_cnt++;
`else
        tot_cnt++;
        if (busy !== 1'b1 || timed_out !== 1'b0)
            $display("FAIL t3_no_timeout got busy=%b to=%b exp 1 0", busy, timed_out);
        else pass_cnt++;
        yes_btn = 4'b0000;
        no_btn  = 4'b0110;
        tick(7);
        tot_cnt++;
        if (votes_valid !== 1'b1 || votes !== 4'b1001 || timed_out !== 1'b0)
            $display("FAIL t3_done got valid=%b votes=%b to=%b exp 1 1001 0", votes_valid, votes, timed_out);
        else pass_cnt++;
`endif
        close_session();
    endtask

    task automatic test_lock_and_conflict();
        open_session();
        yes_btn = 4'b0101;
        no_btn  = 4'b0001;
        tick(8);
        tot_cnt++;
        if (voted !== 4'b0100 || votes !== 4'b0100)
            $display("FAIL t4_first got voted=%b votes=%b exp 0100 0100", voted, votes);
        else pass_cnt++;
        yes_btn = 4'b0000;
        no_btn  = 4'b0000;
        tick(8);
        no_btn  = 4'b0100;
        tick(8);
        tot_cnt++;
        if (voted !== 4'b0100 || votes !== 4'b0100)
            $display("FAIL t4_locked got voted=%b votes=%b exp 0100 0100", voted, votes);
        else pass_cnt++;
        no_btn  = 4'b0000;
        tick(8);
        yes_btn = 4'b0010;
        no_btn  = 4'b1001;
        tick(7);
        tot_cnt++;
        if (votes_valid !== 1'b1 || votes !== 4'b0110 || voted !== 4'b1111)
            $display("FAIL t4_done got valid=%b votes=%b voted=%b exp 1 0110 1111", votes_valid, votes, voted);
        else pass_cnt++;
        close_session();
    endtask

    task automatic test_held_and_clear_start();
        yes_btn = 4'b0010;
        tick(8);
        open_session();
        tick(10);
        tot_cnt++;
        if (voted !== 4'b0000) $display("FAIL t5_held got voted=%b exp=0000", voted);
        else pass_cnt++;
        yes_btn = 4'b0000;
        tick(8);
        yes_btn = 4'b1111;
        tick(7);
        tot_cnt++;
        if (votes_valid !== 1'b1 || votes !== 4'b1111)
            $display("FAIL t5_repress got valid=%b votes=%b exp 1 1111", votes_valid, votes);
        else pass_cnt++;
        start = 1'b1;
        clear = 1'b1;
        tick(1);
        start = 1'b0;
        clear = 1'b0;
        tot_cnt++;
        if (votes_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL t5_clear_wins got valid=%b busy=%b exp 0 0", votes_valid, busy);
        else pass_cnt++;
        yes_btn = 4'b0000;
        tick(10);
    endtask

    task automatic test_reset_mid_session();
        open_session();
        yes_btn = 4'b0001;
        no_btn  = 4'b0010;
        tick(7);
        tot_cnt++;
        if (voted !== 4'b0011 || votes !== 4'b0001)
            $display("FAIL t6_partial got voted=%b votes=%b exp 0011 0001", voted, votes);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        tot_cnt++;
        if ({votes, voted, votes_valid, busy, timed_out} !== 11'b0)
            $display("FAIL t6_async_reset got=%b exp=%b", {votes, voted, votes_valid, busy, timed_out}, 11'b0);
        else pass_cnt++;
        yes_btn = 4'b0000;
        no_btn  = 4'b0000;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        tot_cnt++;
        if (busy !== 1'b0 || votes_valid !== 1'b0 || voted !== 4'b0000)
            $display("FAIL t6_idle got busy=%b valid=%b voted=%b exp 0 0 0000", busy, votes_valid, voted);
        else pass_cnt++;
        open_session();
        tot_cnt++;
        if (busy !== 1'b1) $display("FAIL t6_restart got busy=%b exp=1", busy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_vote();
        test_glitch();
        test_timeout();
        test_lock_and_conflict();
        test_held_and_clear_start();
        test_reset_mid_session();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/vote_collector.md
Name: vote_collector

Overview:
Front-end stage feeding the 4-voter majority/tie vote circuit.
- Runs a voting session.
- Synchronises and debounces one YES and one NO button per voter.
- Locks each voter's first valid press.
- Closes the session when all four have voted or a timeout expires.
- Holds the 4-bit YES vector stable with a valid flag for the downstream winner/tie logic.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to change a debounced level (>=1)
TIMEOUT_CYCLES, 1000, max cycles a session stays OPEN (>=1; used only with VOTE_TIMEOUT_EN)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  open a session (honoured only in IDLE)
clear  input  1  release result, return to IDLE (honoured only in DONE)
yes_btn  input  4  raw asynchronous YES buttons, bit i = voter i
no_btn  input  4  raw asynchronous NO buttons, bit i = voter i
votes  output  4  latched YES vector; drives vote circuit `in`
voted  output  4  bit i set once voter i has cast a vote this session
votes_valid  output  1  high while in DONE; votes stable
busy  output  1  high while in OPEN
timed_out  output  1  in DONE: session closed by timeout

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state IDLE.
  - Sync flops, debounce counters and debounced levels 0; timer 0.
  - Release is synchronous to clk.
- Input conditioning, per button (8 instances):
  - 2-flop synchroniser.
  - Counter of consecutive synchroniser-output samples differing from the current debounced level; resets on any agreeing sample.
  - Debounced level toggles at the edge where the count reaches DEBOUNCE_CYCLES.
  - Debouncers run in all states.
- Latency: button first sampled high at edge 1, held stable → debounced level rises at edge 2+DEBOUNCE_CYCLES → vote registers at edge 3+DEBOUNCE_CYCLES. Default: edge 7.
- Vote registration, OPEN only, voter i with voted[i]=0:
  - Debounced YES rising edge, debounced NO low → voted[i]=1, votes[i]=1.
  - Debounced NO rising edge, debounced YES low → voted[i]=1, votes[i]=0.
  - Both rising the same cycle, or one rising while the other is high → ignored.
  - Once voted[i]=1, further presses are ignored (first vote locks).
  - Only rising edges count. A button already debounced-high when the session opens must be released and pressed again.
- FSM:
  - IDLE: busy=0, votes_valid=0.
    - start=1 → OPEN next edge.
    - Entering OPEN clears votes, voted, timed_out and the timer.
  - OPEN: busy=1; timer increments every cycle.
    - voted==4'b1111 (including the fourth vote registering this edge) → DONE.
    - Else timeout condition → DONE with timed_out=1.
    - start ignored.
  - DONE: votes_valid=1, busy=0; votes, voted and timed_out frozen.
    - clear=1 → IDLE next edge; votes, voted and timed_out remain until the next start.
    - start ignored. clear and start together → clear wins.
- Closing rules:
  - A vote registering on the same edge as the timeout is included; in that case timed_out=0 if it completes 4'b1111.
  - Voters that never voted count as 0 in votes.
- clear outside DONE: no effect.
- Reset mid-session: immediate return to IDLE with all outputs 0; partial votes are discarded.

Optional Feature:
VOTE_TIMEOUT_EN
- Defined:
  - 16-bit timer; OPEN→DONE at the edge where the timer reaches TIMEOUT_CYCLES-1 (session length exactly TIMEOUT_CYCLES cycles).
  - timed_out set accordingly.
- Undefined:
  - No timer logic; OPEN exits only on voted==4'b1111.
  - timed_out tied 0; TIMEOUT_CYCLES unused.

Test Plan:
1. Defaults, reset, start. Voters 0,1,2 press YES held 8 cycles; voter 3 presses NO. → voted[0] rises at edge 7 after press; DONE with votes=4'b0111, votes_valid=1, timed_out=0, busy=0.
2. OPEN; yes_btn[1] high 3 cycles then low; then yes_btn[1] high 10 cycles. → voted[1] stays 0 after the glitch; then voted[1]=1, votes[1]=1.
3. VOTE_TIMEOUT_EN, TIMEOUT_CYCLES=64. Only voters 0 and 3 press YES. → DONE exactly 64 cycles after entering OPEN; votes=4'b1001, voted=4'b1001, timed_out=1.
4. Voter 2 presses YES, releases, then presses NO; yes_btn[0] and no_btn[0] rise the same cycle. → votes[2]=1 (locked); voted[0]=0.
5. YES held on voter 1 during the start pulse. → no vote registers until release and re-press. In DONE, assert start and clear together → IDLE; votes_valid=0.
6. Two votes registered; drive rst_n=0 mid-OPEN. → all outputs 0 asynchronously, before the next clock edge; after release, state IDLE and start required.
